// File: rtl/rst_seq_if.sv
// rst_seq_if: PLL lock/soft-reset inputs and ordered domain reset outputs of the reset sequencer
interface rst_seq_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       sdram_rst;
  logic       sys_rst;
  logic       vga_rst;
  logic       cpu_rst;
  logic       ready;
  logic [3:0] retries;
  modport master (
    input  pll_locked, sw_rst_req,
    output pll_rst, sdram_rst, sys_rst, vga_rst, cpu_rst, ready, retries
  );
  modport slave (
    output pll_locked, sw_rst_req,
    input  pll_rst, sdram_rst, sys_rst, vga_rst, cpu_rst, ready, retries
  );
endinterface

// File: rtl/rst_seq.sv
// rst_seq: PLL reset + ordered SDRAM/sys/VGA/CPU reset release after stable lock; RST_SEQ_WDT_EN adds the lock-timeout watchdog
module rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_HOLD      = 1024,
  parameter int STAGE_GAP      = 64,
  parameter int LOCK_TIMEOUT   = 2400000
) (
  input logic       clk24_ref,
  input logic       rst_n,
  rst_seq_if.master bus
);
  localparam int M1 = PLL_RST_CYCLES > LOCK_HOLD ? PLL_RST_CYCLES : LOCK_HOLD;
  localparam int M2 = M1 > 3 * STAGE_GAP ? M1 : 3 * STAGE_GAP;
  localparam int M3 = M2 > LOCK_TIMEOUT ? M2 : LOCK_TIMEOUT;
  localparam int CW = $clog2(M3 + 1);
  typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_HOLD, S_RELEASE, S_RUN} state_e;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  logic                   pll_rst_q, pll_rst_d;
  logic [3:0]             rst_q, rst_d;
  logic                   ready_q, ready_d;
  assign lk = sync_q[SYNC_STAGES-1];
  // state, shared counter, lock synchroniser and registered outputs
  always_ff @(posedge clk24_ref or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      pll_rst_q <= pll_rst_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
    end
`ifdef RST_SEQ_WDT_EN
  logic       timeout;
  logic [3:0] retries_q, retries_d;
`endif
  // next state; the lock-detect cycle in WAIT_LOCK already counts as the first held cycle
  always_comb begin
    state_d = state_q;
`ifdef RST_SEQ_WDT_EN
    timeout = 1'b0;
`endif
    case (state_q)
      S_PLL_RST:   if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lk) state_d = LOCK_HOLD == 1 ? S_RELEASE : S_HOLD;
`ifdef RST_SEQ_WDT_EN
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = S_PLL_RST;
          timeout = 1'b1;
        end
`endif
      end
      S_HOLD:    state_d = !lk ? S_WAIT_LOCK : (!bus.sw_rst_req && cnt_q == CW'(LOCK_HOLD - 1)) ? S_RELEASE : S_HOLD;
      S_RELEASE: state_d = !lk ? S_WAIT_LOCK : bus.sw_rst_req ? S_HOLD : cnt_q == CW'(3 * STAGE_GAP - 1) ? S_RUN : S_RELEASE;
      S_RUN:     state_d = !lk ? S_WAIT_LOCK : bus.sw_rst_req ? S_HOLD : S_RUN;
      default:   state_d = S_PLL_RST;
    endcase
    cnt_d = state_d != state_q ? CW'(state_q == S_WAIT_LOCK && state_d == S_HOLD) :
            ((state_q == S_HOLD && bus.sw_rst_req) || state_q == S_RUN) ? '0 : cnt_q + 1'b1;
  end
  // outputs decoded from the next state so every release lands on the edge that enters it
  always_comb begin
    pll_rst_d = state_d == S_PLL_RST;
    ready_d   = state_d == S_RUN;
    for (int i = 0; i < 4; i++)
      rst_d[i] = !(ready_d || (state_d == S_RELEASE && cnt_d >= CW'(i * STAGE_GAP)));
`ifdef RST_SEQ_WDT_EN
    retries_d = retries_q + 4'(timeout && retries_q != 4'hf);
`endif
  end
`ifdef RST_SEQ_WDT_EN
  // saturating lock-timeout count, cleared only by rst_n
  always_ff @(posedge clk24_ref or negedge rst_n)
    if (!rst_n) retries_q <= '0;
    else retries_q <= retries_d;
  assign bus.retries = retries_q;
`else
  assign bus.retries = '0;
`endif
  assign bus.pll_rst   = pll_rst_q;
  assign bus.sdram_rst = rst_q[0];
  assign bus.sys_rst   = rst_q[1];
  assign bus.vga_rst   = rst_q[2];
  assign bus.cpu_rst   = rst_q[3];
  assign bus.ready     = ready_q;
endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer on the board reference clock, at the consumer end of the clock generator. Drives the PLL reset and watches its lock output. Releases per-domain resets in a fixed order once lock has been stable: SDRAM, then system, then VGA, then CPU. Re-sequences on lock loss or a soft-reset request.

## Interface
- SYNC_STAGES, 2: flip-flop stages synchronising `pll_locked` (≥2)
- PLL_RST_CYCLES, 8: cycles `pll_rst` is held high per PLL reset pulse (≥1)
- LOCK_HOLD, 1024: consecutive synchronised-lock cycles required before release (≥1)
- STAGE_GAP, 64: cycles between successive domain reset releases (≥1)
- LOCK_TIMEOUT, 2400000: cycles in WAIT_LOCK before re-pulsing `pll_rst` (≥1)
- clk24_ref  in  1  free-running 24 MHz board reference clock; sole clock
- rst_n  in  1  asynchronous, active-low reset (power-on/button)
- pll_locked  in  1  PLL LOCKED, asynchronous to clk24_ref
- sw_rst_req  in  1  synchronous soft-reset request, sampled every cycle
- pll_rst  out  1  PLL reset, active high
- sdram_rst  out  1  SDRAM controller reset, active high
- sys_rst  out  1  system-bus reset, active high
- vga_rst  out  1  VGA reset, active high
- cpu_rst  out  1  CPU/bus-bridge reset, active high
- ready  out  1  high in RUN only
- retries  out  4  saturating count of lock timeouts since `rst_n`

## Operation
- All outputs are registered.
- Reset values: `pll_rst`=1, all four domain resets=1, `ready`=0, `retries`=0, state=PLL_RST, all counters 0.
- Downstream domains re-synchronise deassertion locally; this block guarantees ordering only in clk24_ref cycles.
- `lk` is `pll_locked` after SYNC_STAGES flops.
- States:
  - PLL_RST: `pll_rst`=1 for PLL_RST_CYCLES cycles, then WAIT_LOCK. Domain resets stay 1.
  - WAIT_LOCK: `pll_rst`=0, timeout counter runs.
    - `lk`=1 → HOLD, counter cleared.
    - Counter reaches LOCK_TIMEOUT-1 → PLL_RST, `retries`+1 (saturates at 15).
  - HOLD: counts cycles with `lk`=1.
    - `lk`=0 → WAIT_LOCK.
    - Count reaches LOCK_HOLD-1 → RELEASE.
  - RELEASE: stage counter from 0.
    - `sdram_rst` drops on the first RELEASE cycle.
    - `sys_rst` drops at +STAGE_GAP, `vga_rst` at +2·STAGE_GAP, `cpu_rst` at +3·STAGE_GAP.
    - → RUN on the cycle `cpu_rst` drops; `ready` rises that same cycle.
  - RUN: steady state.
- Lock loss (`lk`=0) in HOLD, RELEASE or RUN:
  - All four domain resets and `ready` reassert on the next edge; → WAIT_LOCK.
  - `pll_rst` is not pulsed.
- `sw_rst_req`=1 in RELEASE or RUN:
  - All domain resets reassert and `ready`=0 on the next edge; → HOLD, counter cleared.
  - The PLL is untouched.
  - Ignored in PLL_RST and WAIT_LOCK; in HOLD it restarts the hold count.
- Simultaneous lock loss and `sw_rst_req`: lock loss wins (→ WAIT_LOCK).
- A domain reset, once dropped, reasserts only together with all others. Release order is never violated.
- `rst_n` low at any time: immediate asynchronous return to reset values.

## Timing
- Cycle 0 = first rising edge with `rst_n` high.
- `pll_rst` is high through cycle PLL_RST_CYCLES-1 and low from cycle PLL_RST_CYCLES.
- `pll_locked` rising at edge t is seen as `lk` at edge t+SYNC_STAGES. The same latency applies to falling lock.
- Release latency from `lk` rise to `sdram_rst` drop is LOCK_HOLD cycles.
- Lock loss → all resets high takes SYNC_STAGES+1 cycles from the `pll_locked` edge.
- `sw_rst_req` → resets high takes 1 cycle.

## Configuration
- `RST_SEQ_WDT_EN` defined: lock-timeout watchdog present, with the WAIT_LOCK timeout, PLL re-pulse and `retries` as above.
- Not defined:
  - WAIT_LOCK waits indefinitely; `pll_rst` pulses only once after `rst_n`.
  - `retries` is tied to 0; LOCK_TIMEOUT is unused.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=3, LOCK_HOLD=4, STAGE_GAP=2, LOCK_TIMEOUT=20.
- Clean bring-up: raise `pll_locked` at cycle 10 → `pll_rst` high cycles 0–2; `sdram_rst` low at 16, `sys_rst` at 18, `vga_rst` at 20, `cpu_rst` and `ready` at 22.
- Glitchy lock: `pll_locked` high cycles 10–12, low 13, high from 14 → no release at 16; `sdram_rst` first drops at 20.
- Lock loss in RUN: drop `pll_locked` at cycle 40 → all resets high and `ready`=0 at 43; `pll_rst` stays 0; re-lock at 50 → `sdram_rst` low at 56.
- Soft reset: `sw_rst_req` pulse at cycle 30 while in RUN → all resets high at 31; `sdram_rst` low again at 35, `cpu_rst` at 41.
- Watchdog (with `RST_SEQ_WDT_EN`): `pll_locked` held 0 → `pll_rst` re-pulses high at cycles 23–25 and 46–48; `retries`=1 then 2. Without the macro: no re-pulse, `retries`=0.
- Async reset mid-RELEASE: `rst_n` low at cycle 19 → all outputs at reset values immediately; restart matches the clean bring-up timing.
